// File: rtl/sda_kernel_run_ctrl.sv
// Kernel run/status sequencer: ap_ctrl control word, go/done handshake to the action core, kernel interrupt.
// Define SDA_KERNEL_RUN_CTRL_IRQ_EN to build the GIE/IER/ISR interrupt registers; otherwise they read 0.
module sda_kernel_run_ctrl #(
  parameter bit AUTO_RESTART_ALLOW = 1'b1
) (
  input  logic        ap_clk,
  input  logic        ap_rst_n,
  input  logic        reg_req,
  output logic        reg_ack,
  input  logic        reg_write_en,
  input  logic [1:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        action_go_valid,
  input  logic        action_go_holdoff,
  input  logic        action_done_valid,
  output logic        action_done_stop,
  output logic        ap_interrupt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REG_CTRL = 2'd0,
    REG_GIE  = 2'd1,
    REG_IER  = 2'd2,
    REG_ISR  = 2'd3
  } reg_sel_t;

  state_t      state;
  state_t      state_nxt;
  reg_sel_t    reg_sel;
  logic        go_acc;
  logic        done_acc;
  logic        wr_req;
  logic        rd_req;
  logic        wr_ctrl;
  logic        rd_ctrl;
  logic        start_pending;
  logic        ap_done;
  logic        ap_ready;
  logic        ap_idle;
  logic        auto_restart;
  logic [31:0] ctrl_word;
  logic [31:0] irq_word;
  logic [31:0] rd_word;
  logic        unused_wdata;

  assign reg_sel = reg_sel_t'(reg_addr);
  assign wr_req  = reg_req & reg_write_en;
  assign rd_req  = reg_req & ~reg_write_en;
  assign wr_ctrl = wr_req & (reg_sel == REG_CTRL);
  assign rd_ctrl = rd_req & (reg_sel == REG_CTRL);

  assign unused_wdata = &{1'b0, reg_wdata[31:8], reg_wdata[6:1]};

  // ---------------------------------------------------------------- run FSM
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    action_go_valid  = 1'b0;
    action_done_stop = 1'b1;
    go_acc           = 1'b0;
    done_acc         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_pending) state_nxt = ST_GO;
      end
      ST_GO: begin
        action_go_valid = 1'b1;
        if (!action_go_holdoff) begin
          go_acc    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        action_done_stop = 1'b0;
        if (action_done_valid) begin
          done_acc  = 1'b1;
          state_nxt = start_pending ? ST_GO : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign ap_idle = (state == ST_IDLE);

  // ------------------------------------------------------------ CTRL word
  // Set terms are OR-ed after the clear terms so a same-cycle event always survives a read or go.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      start_pending <= 1'b0;
      ap_done       <= 1'b0;
      ap_ready      <= 1'b0;
    end else begin
      start_pending <= (start_pending & ~(go_acc & ~auto_restart)) | (wr_ctrl & reg_wdata[0]);
      ap_done       <= (ap_done & ~rd_ctrl) | done_acc;
      ap_ready      <= (ap_ready & ~rd_ctrl) | go_acc;
    end
  end

  if (AUTO_RESTART_ALLOW) begin : g_auto_restart
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
        auto_restart <= 1'b0;
      end else if (wr_ctrl) begin
        auto_restart <= reg_wdata[7];
      end
    end
  end else begin : g_no_auto_restart
    assign auto_restart = 1'b0;
  end

  assign ctrl_word = {24'd0, auto_restart, 3'd0, ap_ready, ap_idle, ap_done, start_pending};

  // ------------------------------------------------------ interrupt block
`ifdef SDA_KERNEL_RUN_CTRL_IRQ_EN
  logic       gie;
  logic [1:0] ier;
  logic [1:0] isr;
  logic [1:0] isr_set;
  logic [1:0] isr_tgl;
  logic       wr_gie;
  logic       wr_ier;
  logic       wr_isr;

  assign wr_gie  = wr_req & (reg_sel == REG_GIE);
  assign wr_ier  = wr_req & (reg_sel == REG_IER);
  assign wr_isr  = wr_req & (reg_sel == REG_ISR);
  assign isr_set = {go_acc & ier[1], done_acc & ier[0]};
  assign isr_tgl = wr_isr ? reg_wdata[1:0] : 2'b00;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      gie          <= 1'b0;
      ier          <= '0;
      isr          <= '0;
      ap_interrupt <= 1'b0;
    end else begin
      if (wr_gie) gie <= reg_wdata[0];
      if (wr_ier) ier <= reg_wdata[1:0];
      isr          <= isr_set | (isr ^ isr_tgl);
      ap_interrupt <= gie & (isr[0] | isr[1]);
    end
  end

  always_comb begin
    irq_word = '0;
    case (reg_sel)
      REG_GIE: irq_word[0]   = gie;
      REG_IER: irq_word[1:0] = ier;
      REG_ISR: irq_word[1:0] = isr;
      default: irq_word      = '0;
    endcase
  end
`else
  assign irq_word     = '0;
  assign ap_interrupt = 1'b0;
`endif

  // ------------------------------------------------------- register port
  assign rd_word = (reg_sel == REG_CTRL) ? ctrl_word : irq_word;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      reg_ack   <= 1'b0;
      reg_rdata <= '0;
    end else begin
      reg_ack   <= reg_req;
      reg_rdata <= rd_req ? rd_word : '0;
    end
  end

endmodule

// File: doc/sda_kernel_run_ctrl.md
# sda_kernel_run_ctrl

Run/status sequencer between the SDAccel host control registers and the generated action core's SELF go/done handshake. It implements the standard kernel control word (ap_start/ap_done/ap_idle/ap_ready/auto_restart), drives one action run per start, and raises the kernel interrupt. It sits behind the AXI slave register selector, on the wrapper register request bus, and replaces the bare control register in wrappers that need interrupts or auto-restart.

## Interface
- AUTO_RESTART_ALLOW, 1: when 0, control bit 7 is read-only zero and auto-restart is never used.
- ap_clk  in  1  kernel clock; every flop is clocked on the rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- reg_req  in  1  single-cycle register access request.
- reg_ack  out  1  single-cycle acknowledge, one cycle after reg_req.
- reg_write_en  in  1  1 = write, 0 = read; sampled with reg_req.
- reg_addr  in  2  register index: 0 CTRL, 1 GIE, 2 IER, 3 ISR.
- reg_wdata  in  32  write data; sampled with reg_req.
- reg_rdata  out  32  read data; valid with reg_ack; zero otherwise.
- action_go_valid  out  1  run request to the action core.
- action_go_holdoff  in  1  action stall; go is accepted on a cycle with go_valid=1 and holdoff=0.
- action_done_valid  in  1  run-complete indication from the action core.
- action_done_stop  out  1  done backpressure; done is accepted on a cycle with done_valid=1 and done_stop=0.
- ap_interrupt  out  1  level interrupt, registered.

## Operation
- CTRL bit 0 start_pending: write 1 sets it. Write 0 has no effect. It clears when go is accepted, unless auto_restart=1.
- CTRL bit 1 ap_done: sets on done acceptance. It clears when CTRL is read.
- CTRL bit 2 ap_idle: 1 when state is IDLE.
- CTRL bit 3 ap_ready: sets on go acceptance. It clears when CTRL is read.
- CTRL bit 7 auto_restart: read/write.
- All other CTRL bits read 0.
- Writes to CTRL bits 1-3 are ignored.
- State machine:
  - IDLE -> GO when start_pending=1.
  - GO -> RUN when go is accepted.
  - RUN -> GO when done is accepted and start_pending=1.
  - RUN -> IDLE when done is accepted and start_pending=0.
- action_go_valid = 1 only in GO.
- action_done_stop = 0 only in RUN.
- Go and done are never accepted in the same cycle.
- Clear-on-read while the bit is being set in the same cycle: the read returns the old value and the bit ends up set. No event is lost.
- ISR[0] sets on done acceptance when IER[0]=1.
- ISR[1] sets on go acceptance when IER[1]=1.
- Writing ISR toggles each bit where wdata is 1. If a set event and a toggle hit the same bit in the same cycle, the set wins.
- GIE is bit 0 of register 1. IER is bits [1:0] of register 2. All unused bits read 0.
- ap_interrupt is registered as GIE & (ISR[0] | ISR[1]).
- Reset clears all registers and outputs and returns the state machine to IDLE.
- Reset mid-run abandons the run with no done reported. The action core is reset by its own domain.

## Timing
- Reset values:
  - reg_ack=0, reg_rdata=0.
  - action_go_valid=0, action_done_stop=1.
  - ap_interrupt=0.
  - CTRL reads 0x4 (idle).
- Register access latency is exactly 1 cycle: req at cycle N gives ack and rdata at N+1.
- A write takes effect at N+1.
- reg_req may be asserted on back-to-back cycles.
- start write at N -> action_go_valid=1 at N+2 (state GO registered at N+2).
- Go accepted at M -> state RUN at M+1, action_done_stop=0 at M+1.
- Done accepted at D:
  - ap_done=1 at D+1.
  - ISR[0]=1 at D+1 when enabled.
  - ap_interrupt=1 at D+2 when GIE=1.
- Auto-restart: done accepted at D -> action_go_valid=1 at D+1.
- ap_idle stays 0 throughout an auto-restart run.

## Configuration
- SDA_KERNEL_RUN_CTRL_IRQ_EN defined: GIE, IER and ISR are implemented as described above.
- SDA_KERNEL_RUN_CTRL_IRQ_EN undefined:
  - registers 1-3 read 0 and ignore writes;
  - ap_interrupt is tied to 0;
  - no interrupt flops are built;
  - CTRL behaviour is unchanged.

## Test plan
- Reset, then read CTRL -> rdata=0x00000004, ack one cycle after req, action_go_valid=0, action_done_stop=1.
- Write CTRL=0x1 with holdoff=1 for 5 cycles -> go_valid held high throughout. After holdoff falls -> first CTRL read returns 0x8, second read returns 0x0.
- With GIE=1 and IER=0x1, inject done_valid 10 cycles after go -> CTRL read returns 0x6 then 0x4. ap_interrupt rises 2 cycles after done. Writing ISR=0x1 drops ap_interrupt.
- Write CTRL=0x81, run 3 done events -> 3 go acceptances with no idle gap. Then write CTRL=0x0 during the 3rd run -> exactly one more go, then IDLE (CTRL=0x4 once the sticky bits have been read).
- CTRL read issued in the same cycle as done acceptance -> that read shows ap_done=0, the next read shows ap_done=1.
- Deassert ap_rst_n while in RUN -> all outputs return to reset values immediately. After release, CTRL=0x4 and no go occurs.
